spi_scheduler: RTL and testbench
================================

SPI_SCHEDULER -- requirements
Module: spi_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096: the WAIT watchdog limit in clk cycles, used only when SPI_SCHEDULER_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req, input, N_REQ bits: per-requester transaction request, held high until its done bit pulses.
REQ-006 SHALL have port req_tx, input, N_REQ*SPI_DATA_W bits: per-requester word to send; slice i is for requester i.
REQ-007 SHALL have port done, output, N_REQ bits: one-hot, one-cycle completion pulse to the served requester.
REQ-008 SHALL have port rdata, output, SPI_DATA_W bits: received word; valid in the done cycle.
REQ-009 SHALL have port err, output, 1 bit: timeout flag; valid in the done cycle.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have ports spi_data_in (SPI_DATA_W bits), spi_address (SPI_ADDR_W bits), spi_we (1 bit) and spi_sel (1 bit), all outputs: the master control bus.
REQ-012 SHALL have ports spi_data_out (SPI_DATA_W bits) and spi_interrupt (1 bit), both inputs: master read data and completion pulse.

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD_TX, START, WAIT, READ and DONE.
REQ-014 SHALL, in IDLE with any req bit high, register the winning index and go to LOAD_TX on the next cycle; with req all zero it SHALL stay in IDLE.
REQ-015 SHALL arbitrate round-robin: search starts at last_grant+1 modulo N_REQ; last_grant resets to N_REQ-1, so requester 0 wins first.
REQ-016 SHALL, in LOAD_TX, drive spi_sel=1, spi_we=1, spi_address=SPI_TX and spi_data_in=req_tx slice of the winner for exactly one cycle, then go to START.
REQ-017 SHALL, in START, drive spi_sel=1, spi_we=1, spi_address=SPI_START for exactly one cycle, then go to WAIT.
REQ-018 SHALL, in WAIT, drive spi_sel=0 and spi_we=0, and go to READ in the cycle after spi_interrupt is sampled high.
REQ-019 SHALL, in READ, drive spi_sel=1, spi_we=0, spi_address=SPI_RX, register spi_data_out into rdata at the end of the cycle, then go to DONE.
REQ-020 SHALL, in DONE, pulse done[winner] for one cycle with err and rdata stable, update last_grant to the winner, and return to IDLE.
REQ-021 SHALL give a minimum latency of 5 cycles from the IDLE cycle with req to the done pulse, plus the WAIT duration.
REQ-022 SHALL drive spi_sel=0, spi_we=0, spi_address=0 and spi_data_in=0 in IDLE and DONE.
REQ-023 SHALL complete a transaction whose req drops mid-transaction, including its done pulse; a requester SHALL NOT be re-granted in the same IDLE cycle in which its done pulsed.
REQ-024 SHALL ignore spi_interrupt outside WAIT.
REQ-025 SHALL ignore req changes of non-winners until the next IDLE.
REQ-026 SHALL hold rdata between transactions; rdata changes only at the end of READ.

Reset
REQ-027 SHALL, when rst is sampled high, put the state in IDLE with done=0, rdata=0, err=0, busy=0, last_grant=N_REQ-1 and the timeout counter at 0.
REQ-028 SHALL let rst abort any state, including WAIT, without a done pulse; no bus write SHALL be issued in the reset cycle.

Configuration
REQ-029 SHALL, with SPI_SCHEDULER_TIMEOUT_EN defined, count cycles in WAIT; when the count reaches TIMEOUT_CYC-1 without spi_interrupt, it SHALL go to DONE with err=1 and rdata=0, skipping READ.
REQ-030 SHALL, with SPI_SCHEDULER_TIMEOUT_EN defined and spi_interrupt arriving in the same cycle as expiry, give the interrupt priority (normal READ path).
REQ-031 SHALL, without SPI_SCHEDULER_TIMEOUT_EN, tie err to 0, include no counter, and wait in WAIT indefinitely.

Structure
REQ-032 SHALL take SPI_DATA_W, SPI_ADDR_W, SPI_START, SPI_TX and SPI_RX from the shared spi_defines.vh.
REQ-033 SHALL place the FSM state encodings in the shared spi_defines.vh.
REQ-034 SHALL implement the round-robin search as sub-module spi_rr_arbiter (inputs req and last_grant; outputs grant_idx and any_req; purely combinational).

Verification
REQ-035 SHALL verify the single request: req=4'b0001, req_tx[0]=0xA5, model returns 0x3C -> TX write with 0xA5, START write, RX read, done=4'b0001 with rdata=0x3C.
REQ-036 SHALL verify round-robin: req=4'b1111 held for 4 transactions -> done order 0,1,2,3, then 0 again.
REQ-037 SHALL verify mid-transaction drop: req[2] dropped in WAIT -> transaction completes and done[2] pulses once.
REQ-038 SHALL verify reset in WAIT: rst in WAIT -> IDLE next cycle, no done pulse, first grant again to requester 0.
REQ-039 SHALL verify timeout (TIMEOUT_EN, TIMEOUT_CYC=16): no interrupt -> done after 16 WAIT cycles with err=1 and rdata=0; interrupt on cycle 16 -> err=0.
REQ-040 SHALL verify interrupt filtering: spi_interrupt pulsed in IDLE -> no state change and no bus activity.

Source files
------------

// File: rtl/spi_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_scheduler_pkg
// Brief    : Shared SPI master map, bus widths and scheduler state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package spi_scheduler_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_ADDR_W = 4;

  localparam logic [SPI_ADDR_W-1:0] SPI_TX    = 4'h1;
  localparam logic [SPI_ADDR_W-1:0] SPI_START = 4'h2;
  localparam logic [SPI_ADDR_W-1:0] SPI_RX    = 4'h3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD_TX = 3'd1;
  localparam state_t ST_START   = 3'd2;
  localparam state_t ST_WAIT    = 3'd3;
  localparam state_t ST_READ    = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  // Wide enough for the largest supported requester count (8).
  function automatic logic [7:0] idx_to_onehot(input int idx);
    return 8'b1 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_scheduler_if
// Brief    : Requester handshake plus SPI master control bus of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_scheduler_if import spi_scheduler_pkg::*; #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]            req;
  logic [N_REQ*SPI_DATA_W-1:0] req_tx;
  logic [N_REQ-1:0]            done;
  logic [SPI_DATA_W-1:0]       rdata;
  logic                        err;
  logic                        busy;

  logic [SPI_DATA_W-1:0]       spi_data_in;
  logic [SPI_ADDR_W-1:0]       spi_address;
  logic                        spi_we;
  logic                        spi_sel;
  logic [SPI_DATA_W-1:0]       spi_data_out;
  logic                        spi_interrupt;

  modport master (
    input  req, req_tx, spi_data_out, spi_interrupt,
    output done, rdata, err, busy, spi_data_in, spi_address, spi_we, spi_sel
  );

  modport slave (
    output req, req_tx, spi_data_out, spi_interrupt,
    input  done, rdata, err, busy, spi_data_in, spi_address, spi_we, spi_sel
  );

endinterface
`default_nettype wire

// File: rtl/spi_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_rr_arbiter
// Brief    : Combinational round-robin search starting after last_grant.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any_req
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last_grant) + off) % N_REQ);
      if (req[cand]) begin
        grant_idx = cand;
        any_req   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spi_scheduler
// Brief    : Round-robin scheduler sharing one SPI master among N_REQ clients.
// Macro    : SPI_SCHEDULER_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC.
// Revision : 1.0 - initial release
// ============================================================================
module spi_scheduler import spi_scheduler_pkg::*; #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic            clk,
  input  logic            rst,
  spi_scheduler_if.master bus
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      winner_q, winner_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [SPI_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_req;
  logic                  timeout_hit;

  logic                  spi_sel, spi_we;
  logic [SPI_ADDR_W-1:0] spi_address;
  logic [SPI_DATA_W-1:0] spi_data_in;
  logic [N_REQ-1:0]      done;

  spi_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

`ifdef SPI_SCHEDULER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_WAIT && !bus.spi_interrupt) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out: the limit never matches.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      winner_q     <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          winner_d = grant_idx;
          state_d  = ST_LOAD_TX;
        end
      end
      ST_LOAD_TX: state_d = ST_START;
      ST_START:   state_d = ST_WAIT;
      ST_WAIT: begin
        // Interrupt wins over a same-cycle watchdog expiry.
        if (bus.spi_interrupt) begin
          state_d = ST_READ;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_READ: begin
        rdata_d = bus.spi_data_out;
        err_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        last_grant_d = winner_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced idle while rst is high so an aborted state cannot write.
  always_comb begin
    spi_sel     = 1'b0;
    spi_we      = 1'b0;
    spi_address = '0;
    spi_data_in = '0;
    done        = '0;
    if (!rst) begin
      case (state_q)
        ST_LOAD_TX: begin
          spi_sel     = 1'b1;
          spi_we      = 1'b1;
          spi_address = SPI_TX;
          spi_data_in = bus.req_tx[int'(winner_q)*SPI_DATA_W +: SPI_DATA_W];
        end
        ST_START: begin
          spi_sel     = 1'b1;
          spi_we      = 1'b1;
          spi_address = SPI_START;
        end
        ST_READ: begin
          spi_sel     = 1'b1;
          spi_address = SPI_RX;
        end
        ST_DONE: done = N_REQ'(idx_to_onehot(int'(winner_q)));
        default: ;
      endcase
    end
  end

  assign bus.spi_sel     = spi_sel;
  assign bus.spi_we      = spi_we;
  assign bus.spi_address = spi_address;
  assign bus.spi_data_in = spi_data_in;
  assign bus.done        = done;
  assign bus.rdata       = rdata_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_scheduler
// Brief    : Directed self-checking bench for spi_scheduler with an SPI model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_scheduler;
  import spi_scheduler_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_scheduler_if #(.N_REQ(N)) sif();

  spi_scheduler #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.master)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model: interrupt irq_delay WAIT cycles after the START write.
  logic                  model_irq  = 1'b0;
  logic                  manual_irq = 1'b0;
  logic                  irq_en     = 1'b1;
  int                    irq_delay  = 1;
  int                    irq_cnt    = 0;
  logic [SPI_DATA_W-1:0] model_rdata = '0;

  int                    start_seen = 0, start_cyc = 0, tx_seen = 0, rx_seen = 0;
  int                    bus_act = 0, done_seen = 0, done_cyc = 0;
  logic [SPI_DATA_W-1:0] tx_data = '0, done_rdata = '0;
  logic                  done_err = 1'b0;
  logic [N-1:0]          done_val = '0;

  assign sif.spi_interrupt = model_irq | manual_irq;
  assign sif.spi_data_out  = model_rdata;

  always @(negedge clk) begin
    model_irq = 1'b0;
    if (sif.spi_sel || sif.spi_we || sif.spi_address != '0 || sif.spi_data_in != '0)
      bus_act++;
    if (sif.spi_sel && sif.spi_we && sif.spi_address == SPI_TX) begin
      tx_seen++;
      tx_data = sif.spi_data_in;
    end
    if (sif.spi_sel && sif.spi_we && sif.spi_address == SPI_START) begin
      start_seen++;
      start_cyc = cyc;
      irq_cnt   = irq_delay;
    end else if (irq_cnt > 0) begin
      irq_cnt--;
      if (irq_cnt == 0 && irq_en) model_irq = 1'b1;
    end
    if (sif.spi_sel && !sif.spi_we && sif.spi_address == SPI_RX) rx_seen++;
    if (sif.done != '0) begin
      done_seen++;
      done_cyc   = cyc;
      done_val   = sif.done;
      done_rdata = sif.rdata;
      done_err   = sif.err;
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst     = 1'b1;
    sif.req = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int  base;
    bit  ok;
    base = done_seen;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_seen != base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL %s: no done pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_start(input int budget, input string name);
    int base;
    bit ok;
    base = start_seen;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (start_seen != base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL %s: no START write within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (sif.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL %s: busy still high after %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_manual_irq();
    manual_irq = 1'b1;
    @(negedge clk); #1;
    manual_irq = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (sif.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", sif.busy); else pass_cnt++;
    total_cnt++; if (sif.done !== 4'b0000) $display("FAIL reset_done: got %b want 0000", sif.done); else pass_cnt++;
    total_cnt++; if ({sif.err, sif.rdata} !== 9'h000) $display("FAIL reset_err_rdata: got %b/%h want 0/00", sif.err, sif.rdata); else pass_cnt++;
    total_cnt++;
    if ({sif.spi_sel, sif.spi_we, sif.spi_address, sif.spi_data_in} !== 14'h0)
      $display("FAIL reset_bus: got sel=%b we=%b addr=%h data=%h want all 0", sif.spi_sel, sif.spi_we, sif.spi_address, sif.spi_data_in);
    else pass_cnt++;
    // Enter LOAD_TX, then assert rst inside that cycle: no write may be driven.
    sif.req = 4'b0001;
    @(negedge clk); #1;
    total_cnt++; if (sif.spi_sel !== 1'b1) $display("FAIL load_tx_entry: sel got %b want 1", sif.spi_sel); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if ({sif.spi_sel, sif.spi_we} !== 2'b00) $display("FAIL reset_cycle_write: sel/we got %b want 00", {sif.spi_sel, sif.spi_we}); else pass_cnt++;
    @(negedge clk); #1;
    rst     = 1'b0;
    sif.req = '0;
    total_cnt++; if (sif.busy !== 1'b0) $display("FAIL reset_abort_busy: got %b want 0", sif.busy); else pass_cnt++;
  endtask

  task automatic test_single();
    int c0, b_tx, b_st, b_rx;
    do_reset();
    model_rdata = 8'h3C;
    irq_en      = 1'b1;
    irq_delay   = 1;
    b_tx = tx_seen; b_st = start_seen; b_rx = rx_seen;
    sif.req = 4'b0001;
    c0      = cyc;
    wait_done(50, "single_done");
    sif.req = '0;
    total_cnt++; if (done_val !== 4'b0001) $display("FAIL single_done_val: got %b want 0001", done_val); else pass_cnt++;
    total_cnt++; if (done_rdata !== 8'h3C) $display("FAIL single_rdata: got %h want 3c", done_rdata); else pass_cnt++;
    total_cnt++; if (done_err !== 1'b0) $display("FAIL single_err: got %b want 0", done_err); else pass_cnt++;
    total_cnt++; if (done_cyc - c0 != 5) $display("FAIL single_latency: got %0d want 5", done_cyc - c0); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'hA5) $display("FAIL single_tx_data: got %h want a5", tx_data); else pass_cnt++;
    total_cnt++;
    if ({tx_seen - b_tx, start_seen - b_st, rx_seen - b_rx} !== {32'd1, 32'd1, 32'd1})
      $display("FAIL single_bus_ops: got tx=%0d start=%0d rx=%0d want 1/1/1", tx_seen - b_tx, start_seen - b_st, rx_seen - b_rx);
    else pass_cnt++;
    model_rdata = 8'hEE;
    repeat (4) @(negedge clk);
    #1;
    total_cnt++; if (sif.rdata !== 8'h3C) $display("FAIL rdata_hold: got %h want 3c", sif.rdata); else pass_cnt++;
    total_cnt++; if (sif.busy !== 1'b0) $display("FAIL single_idle: busy got %b want 0", sif.busy); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int           exp_order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] one;
    int           prev_cyc;
    do_reset();
    irq_en    = 1'b1;
    irq_delay = 1;
    prev_cyc  = 0;
    sif.req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(50, "rr_done");
      if (k == 4) sif.req = '0;
      one = 4'b0001;
      total_cnt++;
      if (done_val !== (one << exp_order[k])) $display("FAIL rr_order_%0d: got %b want %b", k, done_val, one << exp_order[k]);
      else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if (done_cyc - prev_cyc != 6) $display("FAIL rr_gap_%0d: got %0d cycles want 6", k, done_cyc - prev_cyc);
        else pass_cnt++;
      end
      prev_cyc = done_cyc;
    end
    wait_idle(20, "rr_idle");
  endtask

  task automatic test_mid_drop();
    int base;
    do_reset();
    irq_en    = 1'b1;
    irq_delay = 6;
    sif.req   = 4'b0100;
    wait_start(20, "drop_start");
    @(negedge clk); #1;
    sif.req = '0;
    base    = done_seen;
    wait_done(50, "drop_done");
    total_cnt++; if (done_val !== 4'b0100) $display("FAIL drop_done_val: got %b want 0100", done_val); else pass_cnt++;
    repeat (10) @(negedge clk);
    #1;
    total_cnt++; if (done_seen - base != 1) $display("FAIL drop_done_count: got %0d want 1", done_seen - base); else pass_cnt++;
    total_cnt++; if (sif.busy !== 1'b0) $display("FAIL drop_idle: busy got %b want 0", sif.busy); else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    int base;
    do_reset();
    irq_en    = 1'b1;
    irq_delay = 1;
    sif.req   = 4'b0001;
    wait_done(50, "rw_first_done");
    sif.req = '0;
    wait_idle(20, "rw_idle");
    irq_en  = 1'b0;
    sif.req = 4'b0010;
    wait_start(20, "rw_start");
    repeat (3) @(negedge clk);
    #1;
    base    = done_seen;
    rst     = 1'b1;
    sif.req = '0;
    @(negedge clk); #1;
    total_cnt++; if (sif.busy !== 1'b0) $display("FAIL rw_abort_busy: got %b want 0", sif.busy); else pass_cnt++;
    rst     = 1'b0;
    irq_en  = 1'b1;
    sif.req = 4'b1111;
    wait_done(50, "rw_regrant_done");
    sif.req = '0;
    total_cnt++; if (done_val !== 4'b0001) $display("FAIL rw_first_grant: got %b want 0001", done_val); else pass_cnt++;
    total_cnt++; if (done_seen - base != 1) $display("FAIL rw_no_abort_done: got %0d pulses want 1", done_seen - base); else pass_cnt++;
    wait_idle(20, "rw_final_idle");
  endtask

  task automatic test_irq_filter();
    int b_act, b_done;
    do_reset();
    b_act  = bus_act;
    b_done = done_seen;
    pulse_manual_irq();
    repeat (5) @(negedge clk);
    #1;
    total_cnt++; if (sif.busy !== 1'b0) $display("FAIL irq_filter_busy: got %b want 0", sif.busy); else pass_cnt++;
    total_cnt++; if (bus_act != b_act) $display("FAIL irq_filter_bus: got %0d active cycles want 0", bus_act - b_act); else pass_cnt++;
    total_cnt++; if (done_seen != b_done) $display("FAIL irq_filter_done: got %0d pulses want 0", done_seen - b_done); else pass_cnt++;
  endtask

`ifdef SPI_SCHEDULER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    model_rdata = 8'h3C;
    irq_en      = 1'b1;
    irq_delay   = 1;
    sif.req     = 4'b0001;
    wait_done(50, "tmo_pre_done");
    sif.req = '0;
    wait_idle(20, "tmo_pre_idle");
    irq_en  = 1'b0;
    sif.req = 4'b0010;
    wait_done(100, "tmo_expire_done");
    sif.req = '0;
    total_cnt++; if (done_val !== 4'b0010) $display("FAIL tmo_done_val: got %b want 0010", done_val); else pass_cnt++;
    total_cnt++; if (done_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", done_err); else pass_cnt++;
    total_cnt++; if (done_rdata !== 8'h00) $display("FAIL tmo_rdata: got %h want 00", done_rdata); else pass_cnt++;
    total_cnt++; if (done_cyc - start_cyc != 17) $display("FAIL tmo_wait_len: got %0d want 17", done_cyc - start_cyc); else pass_cnt++;
    wait_idle(20, "tmo_idle");
    irq_en      = 1'b1;
    irq_delay   = TMO;
    model_rdata = 8'h5A;
    sif.req     = 4'b0100;
    wait_done(100, "tmo_race_done");
    sif.req = '0;
    total_cnt++; if (done_err !== 1'b0) $display("FAIL tmo_race_err: got %b want 0", done_err); else pass_cnt++;
    total_cnt++; if (done_rdata !== 8'h5A) $display("FAIL tmo_race_rdata: got %h want 5a", done_rdata); else pass_cnt++;
    total_cnt++; if (done_cyc - start_cyc != 18) $display("FAIL tmo_race_len: got %0d want 18", done_cyc - start_cyc); else pass_cnt++;
    wait_idle(20, "tmo_race_idle");
  endtask
`else
  task automatic test_no_timeout();
    int base;
    do_reset();
    irq_en  = 1'b0;
    sif.req = 4'b0001;
    wait_start(20, "nt_start");
    base = done_seen;
    repeat (40) @(negedge clk);
    #1;
    total_cnt++; if (sif.busy !== 1'b1) $display("FAIL nt_still_waiting: busy got %b want 1", sif.busy); else pass_cnt++;
    total_cnt++; if (done_seen != base) $display("FAIL nt_no_done: got %0d pulses want 0", done_seen - base); else pass_cnt++;
    model_rdata = 8'h77;
    pulse_manual_irq();
    wait_done(10, "nt_done");
    sif.req = '0;
    total_cnt++; if (done_err !== 1'b0) $display("FAIL nt_err: got %b want 0", done_err); else pass_cnt++;
    total_cnt++; if (done_rdata !== 8'h77) $display("FAIL nt_rdata: got %h want 77", done_rdata); else pass_cnt++;
    wait_idle(20, "nt_idle");
  endtask
`endif

  initial begin
    sif.req    = '0;
    sif.req_tx = 32'hD4C3B2A5;
    test_reset();
    test_single();
    test_round_robin();
    test_mid_drop();
    test_reset_in_wait();
    test_irq_filter();
`ifdef SPI_SCHEDULER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
